// File: rtl/plab4_net_route_pkg.sv
// Shared route/mode encodings for the ring route-compute stage.
package plab4_net_route_pkg;

    localparam logic [1:0] ROUTE_PREV = 2'b00;
    localparam logic [1:0] ROUTE_NEXT = 2'b01;
    localparam logic [1:0] ROUTE_TERM = 2'b10;

    localparam logic [1:0] MODE_GREEDY     = 2'b00;
    localparam logic [1:0] MODE_ADAPTIVE   = 2'b01;
    localparam logic [1:0] MODE_FIXED_NEXT = 2'b10;
    localparam logic [1:0] MODE_FIXED_PREV = 2'b11;

endpackage

// File: rtl/plab4_net_ring_hops.sv
// Ring hop distances from this router to dest, taken modulo the true ring size.
module plab4_net_ring_hops #(
    parameter int p_router_id   = 0,
    parameter int p_num_routers = 8,
    parameter int c_dest_nbits  = $clog2(p_num_routers)
) (
    input  logic [c_dest_nbits-1:0] dest,
    output logic [c_dest_nbits:0]   forw,
    output logic [c_dest_nbits:0]   backw,
    output logic                    tie,
    output logic                    is_self,
    output logic                    out_of_range
);

    localparam logic [c_dest_nbits:0] c_id = p_router_id[c_dest_nbits:0];
    localparam logic [c_dest_nbits:0] c_nr = p_num_routers[c_dest_nbits:0];

    logic [c_dest_nbits:0] dest_x;

    // One extra bit keeps dest + N - id from wrapping on non-power-of-two rings.
    assign dest_x       = {1'b0, dest};
    assign forw         = (dest_x >= c_id) ? dest_x - c_id : dest_x + c_nr - c_id;
    assign backw        = c_nr - forw;
    assign tie          = (forw == backw);
    assign is_self      = (dest_x == c_id);
    assign out_of_range = (dest_x >= c_nr);

endmodule

// File: rtl/plab4_net_adaptive_route_unit.sv
// Route-compute stage: picks PREV/NEXT/TERM at enqueue, buffers 2 entries, credit-gates the head.
module plab4_net_adaptive_route_unit
    import plab4_net_route_pkg::*;
#(
    parameter int p_router_id     = 0,
    parameter int p_num_routers   = 8,
    parameter int p_payload_nbits = 32,
    parameter int p_num_credits   = 4,
    localparam int c_dest_nbits   = $clog2(p_num_routers)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_val,
    output logic                       in_rdy,
    input  logic [c_dest_nbits-1:0]    in_dest,
    input  logic                       in_sd,
    input  logic [p_payload_nbits-1:0] in_payload,
    input  logic [1:0]                 mode,
    input  logic                       credit_next,
    input  logic                       credit_prev,
    output logic                       out_val,
    input  logic                       out_rdy,
    output logic [1:0]                 out_route,
    output logic [c_dest_nbits-1:0]    out_dest,
    output logic                       out_sd,
    output logic [p_payload_nbits-1:0] out_payload,
    output logic                       err
);

    localparam int c_cred_nbits = $clog2(p_num_credits + 1);
    localparam logic [c_cred_nbits-1:0] c_cred_max = p_num_credits[c_cred_nbits-1:0];

    logic [1:0][1:0]                 route_q;
    logic [1:0][c_dest_nbits-1:0]    dest_q;
    logic [1:0]                      sd_q;
    logic [1:0][p_payload_nbits-1:0] pay_q;
    logic                            wr_ptr, rd_ptr;
    logic [1:0]                      count;
    logic [c_cred_nbits-1:0]         cred_next, cred_prev;
    logic                            tie_next_q;
    logic                            err_q;

    logic [c_dest_nbits:0] forw, backw;
    logic                  tie, is_self, out_of_range;
    logic [1:0]            new_route;
    logic                  flip_tie;
    logic                  enq, deq, head_ok, dec_next, dec_prev;

    plab4_net_ring_hops #(
        .p_router_id   (p_router_id),
        .p_num_routers (p_num_routers),
        .c_dest_nbits  (c_dest_nbits)
    ) u_hops (
        .dest         (in_dest),
        .forw         (forw),
        .backw        (backw),
        .tie          (tie),
        .is_self      (is_self),
        .out_of_range (out_of_range)
    );

    always_comb begin
        new_route = (forw < backw) ? ROUTE_NEXT : ROUTE_PREV;
        flip_tie  = 1'b0;
        case (mode)
            MODE_GREEDY: begin
                if (tie) begin
                    new_route = tie_next_q ? ROUTE_NEXT : ROUTE_PREV;
                    flip_tie  = 1'b1;
                end
            end
            MODE_ADAPTIVE: begin
                if (tie) begin
                    if (cred_next > cred_prev)      new_route = ROUTE_NEXT;
                    else if (cred_next < cred_prev) new_route = ROUTE_PREV;
                    else begin
                        new_route = tie_next_q ? ROUTE_NEXT : ROUTE_PREV;
                        flip_tie  = 1'b1;
                    end
                end
            end
            MODE_FIXED_NEXT: new_route = ROUTE_NEXT;
            default:         new_route = ROUTE_PREV;
        endcase
        if (is_self || out_of_range) begin
            new_route = ROUTE_TERM;
            flip_tie  = 1'b0;
        end
    end

    always_comb begin
        case (route_q[rd_ptr])
            ROUTE_NEXT: head_ok = (cred_next != '0);
            ROUTE_PREV: head_ok = (cred_prev != '0);
            default:    head_ok = 1'b1;
        endcase
    end

    assign in_rdy      = reset && (count != 2'd2);
    assign out_val     = (count != 2'd0) && head_ok;
    assign enq         = in_val && in_rdy;
    assign deq         = out_val && out_rdy;
    assign dec_next    = deq && (route_q[rd_ptr] == ROUTE_NEXT);
    assign dec_prev    = deq && (route_q[rd_ptr] == ROUTE_PREV);
    assign out_route   = route_q[rd_ptr];
    assign out_dest    = dest_q[rd_ptr];
    assign out_sd      = sd_q[rd_ptr];
    assign out_payload = pay_q[rd_ptr];
    assign err         = err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            route_q    <= '0;
            dest_q     <= '0;
            sd_q       <= '0;
            pay_q      <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            cred_next  <= c_cred_max;
            cred_prev  <= c_cred_max;
            tie_next_q <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            if (enq) begin
                route_q[wr_ptr] <= new_route;
                dest_q[wr_ptr]  <= in_dest;
                sd_q[wr_ptr]    <= in_sd;
                pay_q[wr_ptr]   <= in_payload;
                wr_ptr          <= ~wr_ptr;
                if (flip_tie)     tie_next_q <= ~tie_next_q;
                if (out_of_range) err_q      <= 1'b1;
            end
            if (deq) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, enq} - {1'b0, deq};

            // A return pulse in the same cycle as a consuming dequeue cancels out.
            if (dec_next && !credit_next)
                cred_next <= cred_next - 1'b1;
            else if (!dec_next && credit_next && cred_next != c_cred_max)
                cred_next <= cred_next + 1'b1;
            if (dec_prev && !credit_prev)
                cred_prev <= cred_prev - 1'b1;
            else if (!dec_prev && credit_prev && cred_prev != c_cred_max)
                cred_prev <= cred_prev + 1'b1;
        end
    end

endmodule

// File: tb/tb_plab4_net_adaptive_route_unit.sv
// Bench for the ring route-compute stage: three configurations share stimulus, one is observed per test.
module tb_plab4_net_adaptive_route_unit;
    import plab4_net_route_pkg::*;

    typedef struct packed {
        logic [1:0]  route;
        logic [2:0]  dest;
        logic        sd;
        logic [31:0] pay;
    } exp_t;

    logic        clk, reset, in_val, in_sd, credit_next, credit_prev, out_rdy;
    logic [2:0]  in_dest;
    logic [31:0] in_payload;
    logic [1:0]  mode;
    logic [2:0]  o_rdy, o_val, o_sd, o_err;
    logic [1:0]  o_route [3];
    logic [2:0]  o_dest  [3];
    logic [31:0] o_pay   [3];

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   sel      = 0;

    // u0: N=8 id=2 credits=4; u1: N=6 id=0 credits=2; u2: N=8 id=0 credits=4
    plab4_net_adaptive_route_unit #(.p_router_id(2), .p_num_routers(8), .p_payload_nbits(32), .p_num_credits(4)) u0 (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(o_rdy[0]), .in_dest(in_dest), .in_sd(in_sd),
        .in_payload(in_payload), .mode(mode), .credit_next(credit_next), .credit_prev(credit_prev),
        .out_val(o_val[0]), .out_rdy(out_rdy), .out_route(o_route[0]), .out_dest(o_dest[0]),
        .out_sd(o_sd[0]), .out_payload(o_pay[0]), .err(o_err[0]));
    plab4_net_adaptive_route_unit #(.p_router_id(0), .p_num_routers(6), .p_payload_nbits(32), .p_num_credits(2)) u1 (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(o_rdy[1]), .in_dest(in_dest), .in_sd(in_sd),
        .in_payload(in_payload), .mode(mode), .credit_next(credit_next), .credit_prev(credit_prev),
        .out_val(o_val[1]), .out_rdy(out_rdy), .out_route(o_route[1]), .out_dest(o_dest[1]),
        .out_sd(o_sd[1]), .out_payload(o_pay[1]), .err(o_err[1]));
    plab4_net_adaptive_route_unit #(.p_router_id(0), .p_num_routers(8), .p_payload_nbits(32), .p_num_credits(4)) u2 (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(o_rdy[2]), .in_dest(in_dest), .in_sd(in_sd),
        .in_payload(in_payload), .mode(mode), .credit_next(credit_next), .credit_prev(credit_prev),
        .out_val(o_val[2]), .out_rdy(out_rdy), .out_route(o_route[2]), .out_dest(o_dest[2]),
        .out_sd(o_sd[2]), .out_payload(o_pay[2]), .err(o_err[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        reset = 1'b0; in_val = 1'b0; credit_next = 1'b0; credit_prev = 1'b0; out_rdy = 1'b0;
        sbq.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Drive one message and queue its expected output.
    task automatic drive(input logic [2:0] d, input logic [1:0] m, input logic [1:0] r);
        exp_t x;
        x.route = r; x.dest = d; x.sd = $urandom_range(0, 1); x.pay = $urandom;
        in_val = 1'b1; in_dest = d; mode = m; in_sd = x.sd; in_payload = x.pay;
        sbq.push_back(x);
    endtask

    task automatic test_reset();
        reset = 1'b0; in_val = 1'b0; credit_next = 1'b1; credit_prev = 1'b1; out_rdy = 1'b1;
        in_dest = '0; in_sd = 1'b0; in_payload = '0; mode = '0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (o_rdy !== 3'b000) begin n_fail++; $display("FAIL reset_in_rdy got=%b exp=000", o_rdy); end
        n_checks++; if (o_val !== 3'b000) begin n_fail++; $display("FAIL reset_out_val got=%b exp=000", o_val); end
        n_checks++; if (o_err !== 3'b000) begin n_fail++; $display("FAIL reset_err got=%b exp=000", o_err); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({o_route[i], o_dest[i], o_sd[i], o_pay[i]} !== 38'd0) begin
                n_fail++; $display("FAIL reset_data dut=%0d got=%h exp=0", i, {o_route[i], o_dest[i], o_sd[i], o_pay[i]});
            end
        end
        credit_next = 1'b0; credit_prev = 1'b0; out_rdy = 1'b0;
        reset = 1'b1;
        #1;
        n_checks++; if (o_rdy !== 3'b111) begin n_fail++; $display("FAIL post_reset_in_rdy got=%b exp=111", o_rdy); end
    endtask

    // Single messages, each checked for one-cycle latency and drained before the next.
    task automatic test_routes();
        int t_sel  [21] = '{0,0,0,0,0,0,0,0, 1,1,1,1,1, 2,2,2,2,2,2,2,2};
        int t_rst  [21] = '{1,0,0,0,0,0,0,0, 1,1,0,0,0, 1,0,0,0,0,0,0,0};
        int t_dest [21] = '{2,3,7,6,6,5,3,2, 5,3,3,3,3, 1,1,1,4,4,1,4,4};
        int t_mode [21] = '{0,0,0,0,0,2,3,3, 0,0,0,0,0, 2,2,2,1,1,3,1,0};
        int t_exp  [21] = '{2,1,0,1,0,1,0,2, 0,1,0,1,0, 1,1,1,0,0,0,1,0};
        exp_t e;
        exp_t got;
        for (int i = 0; i < 21; i++) begin
            if (t_rst[i] != 0) do_reset();
            sel = t_sel[i];
            out_rdy = 1'b1;
            drive(3'(t_dest[i]), 2'(t_mode[i]), 2'(t_exp[i]));
            #1;
            n_checks++; if (o_rdy[sel] !== 1'b1) begin n_fail++; $display("FAIL route_in_rdy idx=%0d got=%b exp=1", i, o_rdy[sel]); end
            @(negedge clk);
            in_val = 1'b0;
            #1;
            n_checks++; if (o_val[sel] !== 1'b1) begin n_fail++; $display("FAIL route_latency idx=%0d got=%b exp=1", i, o_val[sel]); end
            e = sbq.pop_front();
            got = {o_route[sel], o_dest[sel], o_sd[sel], o_pay[sel]};
            n_checks++; if (got !== e) begin n_fail++; $display("FAIL route_out idx=%0d got=%h exp=%h", i, got, e); end
            @(negedge clk);
            #1;
            n_checks++; if (o_val[sel] !== 1'b0) begin n_fail++; $display("FAIL route_drain idx=%0d got=%b exp=0", i, o_val[sel]); end
        end
    endtask

    task automatic test_credit_stall();
        exp_t e;
        exp_t got;
        do_reset();
        sel = 1;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) @(negedge clk);
            case (c)
                0: begin out_rdy = 1'b1; drive(3'd1, MODE_FIXED_NEXT, ROUTE_NEXT); end
                1: drive(3'd2, MODE_FIXED_NEXT, ROUTE_NEXT);
                2: drive(3'd4, MODE_FIXED_NEXT, ROUTE_NEXT);
                3: in_val = 1'b0;
                6: credit_next = 1'b1;
                7: credit_next = 1'b0;
                default: ;
            endcase
            #1;
            if (c <= 2) begin
                n_checks++; if (o_rdy[sel] !== 1'b1) begin n_fail++; $display("FAIL stall_in_rdy c=%0d got=%b exp=1", c, o_rdy[sel]); end
            end
            if (c >= 3 && c <= 6) begin
                n_checks++; if (o_val[sel] !== 1'b0) begin n_fail++; $display("FAIL stall_gated c=%0d got=%b exp=0", c, o_val[sel]); end
            end
            if (c == 7) begin
                n_checks++; if (o_val[sel] !== 1'b1) begin n_fail++; $display("FAIL stall_release got=%b exp=1", o_val[sel]); end
            end
            if (o_val[sel] && out_rdy) begin
                got = {o_route[sel], o_dest[sel], o_sd[sel], o_pay[sel]};
                n_checks++;
                if (sbq.size() == 0) begin n_fail++; $display("FAIL stall_extra_out c=%0d got=%h exp=none", c, got); end
                else begin
                    e = sbq.pop_front();
                    if (got !== e) begin n_fail++; $display("FAIL stall_out c=%0d got=%h exp=%h", c, got, e); end
                end
            end
        end
        n_checks++; if (sbq.size() != 0) begin n_fail++; $display("FAIL stall_left got=%0d exp=0", sbq.size()); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        exp_t got;
        logic [31:0] p1;
        do_reset();
        sel = 1;
        p1 = '0;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) @(negedge clk);
            case (c)
                0: begin out_rdy = 1'b0; drive(3'd1, MODE_FIXED_NEXT, ROUTE_NEXT); p1 = in_payload; end
                1: drive(3'd2, MODE_FIXED_NEXT, ROUTE_NEXT);
                2: drive(3'd3, MODE_FIXED_NEXT, ROUTE_NEXT);
                3: begin out_rdy = 1'b1; credit_next = 1'b1; end
                4: credit_next = 1'b0;
                5: in_val = 1'b0;
                6: drive(3'd1, MODE_FIXED_NEXT, ROUTE_NEXT);
                7: in_val = 1'b0;
                default: ;
            endcase
            #1;
            if (c <= 1 || c == 4) begin
                n_checks++; if (o_rdy[sel] !== 1'b1) begin n_fail++; $display("FAIL b2b_in_rdy c=%0d got=%b exp=1", c, o_rdy[sel]); end
            end
            if (c == 2 || c == 3) begin
                n_checks++; if (o_rdy[sel] !== 1'b0) begin n_fail++; $display("FAIL b2b_full c=%0d got=%b exp=0", c, o_rdy[sel]); end
                n_checks++; if (o_val[sel] !== 1'b1 || o_pay[sel] !== p1) begin
                    n_fail++; $display("FAIL b2b_hold c=%0d got=%b/%h exp=1/%h", c, o_val[sel], o_pay[sel], p1);
                end
            end
            if (c >= 7) begin
                n_checks++; if (o_val[sel] !== 1'b0) begin n_fail++; $display("FAIL b2b_credit_out c=%0d got=%b exp=0", c, o_val[sel]); end
            end
            if (o_val[sel] && out_rdy) begin
                got = {o_route[sel], o_dest[sel], o_sd[sel], o_pay[sel]};
                n_checks++;
                if (sbq.size() == 0) begin n_fail++; $display("FAIL b2b_extra_out c=%0d got=%h exp=none", c, got); end
                else begin
                    e = sbq.pop_front();
                    if (got !== e) begin n_fail++; $display("FAIL b2b_out c=%0d got=%h exp=%h", c, got, e); end
                end
            end
        end
        n_checks++; if (sbq.size() != 1) begin n_fail++; $display("FAIL b2b_left got=%0d exp=1", sbq.size()); end
    endtask

    task automatic test_err_and_reset();
        exp_t e;
        exp_t got;
        do_reset();
        sel = 1;
        for (int c = 0; c < 11; c++) begin
            if (c > 0) @(negedge clk);
            case (c)
                0: begin out_rdy = 1'b1; drive(3'd7, MODE_GREEDY, ROUTE_TERM); end
                1: drive(3'd1, MODE_GREEDY, ROUTE_NEXT);
                2: in_val = 1'b0;
                3: begin out_rdy = 1'b0; drive(3'd2, MODE_GREEDY, ROUTE_NEXT); end
                4: drive(3'd4, MODE_GREEDY, ROUTE_PREV);
                5: begin in_val = 1'b0; reset = 1'b0; credit_next = 1'b1; end
                6: begin credit_next = 1'b0; sbq.delete(); end
                7: begin reset = 1'b1; out_rdy = 1'b1; drive(3'd1, MODE_FIXED_NEXT, ROUTE_NEXT); end
                8: drive(3'd1, MODE_FIXED_NEXT, ROUTE_NEXT);
                9: in_val = 1'b0;
                default: ;
            endcase
            #1;
            if (c == 0) begin
                n_checks++; if (o_err[sel] !== 1'b0) begin n_fail++; $display("FAIL err_initial got=%b exp=0", o_err[sel]); end
            end
            if (c >= 1 && c <= 5) begin
                n_checks++; if (o_err[sel] !== 1'b1) begin n_fail++; $display("FAIL err_sticky c=%0d got=%b exp=1", c, o_err[sel]); end
            end
            if (c == 5) begin
                n_checks++; if (o_val[sel] !== 1'b1) begin n_fail++; $display("FAIL err_buffered got=%b exp=1", o_val[sel]); end
            end
            if (c == 6) begin
                n_checks++; if ({o_val[sel], o_err[sel], o_rdy[sel]} !== 3'b000) begin
                    n_fail++; $display("FAIL midreset val/err/rdy got=%b exp=000", {o_val[sel], o_err[sel], o_rdy[sel]});
                end
            end
            if (c == 9) begin
                n_checks++; if (o_val[sel] !== 1'b1) begin n_fail++; $display("FAIL midreset_credits got=%b exp=1", o_val[sel]); end
            end
            if (o_val[sel] && out_rdy) begin
                got = {o_route[sel], o_dest[sel], o_sd[sel], o_pay[sel]};
                n_checks++;
                if (sbq.size() == 0) begin n_fail++; $display("FAIL err_extra_out c=%0d got=%h exp=none", c, got); end
                else begin
                    e = sbq.pop_front();
                    if (got !== e) begin n_fail++; $display("FAIL err_out c=%0d got=%h exp=%h", c, got, e); end
                end
            end
        end
        n_checks++; if (sbq.size() != 0 || o_val[sel] !== 1'b0) begin
            n_fail++; $display("FAIL err_end left=%0d val=%b exp=0/0", sbq.size(), o_val[sel]);
        end
    endtask

    initial begin
        test_reset();
        test_routes();
        test_credit_stall();
        test_back_to_back();
        test_err_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
